// File: rtl/miner_pkg.sv
// miner_pkg: scheduler state encoding and default parameters (S_WDOG exists only under MINER_WDOG_EN)
package miner_pkg;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_NONCE_W = 32;
  localparam int DEF_WDOG_CYCLES = 1024;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LTARGET,
    S_LMSG,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXHAUST
`ifdef MINER_WDOG_EN
    , S_WDOG
`endif
  } state_e;
endpackage

// File: rtl/core_tracker.sv
// core_tracker: per-core busy bits and nonce slots with lowest-index idle pick and lowest-index winner select
module core_tracker #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W = 32
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [NUM_CORES-1:0] done,
  input  logic [NUM_CORES-1:0] valid,
  output logic [NUM_CORES-1:0] pick,
  output logic any_idle,
  output logic hit,
  output logic [NONCE_W-1:0] hit_nonce,
  output logic [NUM_CORES-1:0] busy
);
  logic [NUM_CORES-1:0] busy_q, busy_d, idle, win;
  logic [NONCE_W-1:0] slot_q [NUM_CORES];
  logic [NONCE_W-1:0] slot_d [NUM_CORES];
  always_comb begin
    idle = ~busy_q;
    pick = idle & (~idle + NUM_CORES'(1));
    any_idle = |idle;
    win = done & valid & busy_q;
    hit = |win;
    hit_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) if (win[i]) hit_nonce = slot_q[i];
    busy_d = clr ? '0 : (busy_q & ~done) | (start ? pick : '0);
    for (int i = 0; i < NUM_CORES; i++) slot_d[i] = (start && pick[i]) ? nonce : slot_q[i];
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      busy_q <= '0;
      slot_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      slot_q <= slot_d;
    end
  assign busy = busy_q;
endmodule

// File: rtl/mining_scheduler.sv
// mining_scheduler: hands sequential nonces to SHA cores, reports the first winning nonce or exhaustion
// MINER_WDOG_EN adds a no-progress watchdog that aborts the search into S_WDOG
module mining_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic new_target,
  input  logic new_msg,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_valid,
  output logic load_target,
  output logic load_msg,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NONCE_W-1:0] core_nonce,
  output logic core_flush,
  output logic btc_found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic error
);
  state_e state_q, state_d;
  logic [NONCE_W-1:0] cnt_q, cnt_d, found_q, found_d, hit_nonce;
  logic wrapped_q, wrapped_d, clr, start, any_idle, hit;
  logic [NUM_CORES-1:0] pick, busy;
  core_tracker #(.NUM_CORES(NUM_CORES), .NONCE_W(NONCE_W)) u_trk (
    .clk(clk),
    .n_rst(n_rst),
    .clr(clr),
    .start(start),
    .nonce(cnt_q),
    .done(core_done),
    .valid(core_valid),
    .pick(pick),
    .any_idle(any_idle),
    .hit(hit),
    .hit_nonce(hit_nonce),
    .busy(busy)
  );
`ifdef MINER_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic wd_fire;
  always_comb begin
    wd_d = ((state_q == S_RUN || state_q == S_DRAIN) && !(|core_done)) ? wd_q + WD_W'(1) : '0;
    wd_fire = (state_q == S_RUN || state_q == S_DRAIN) && !(|core_done) && wd_q == WD_W'(WDOG_CYCLES - 1);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) wd_q <= '0;
    else wd_q <= wd_d;
`else
  logic unused_wdog;
  assign unused_wdog = |WDOG_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    found_d = found_q;
    wrapped_d = wrapped_q;
    load_target = 1'b0;
    load_msg = 1'b0;
    core_flush = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    case (state_q)
      S_LTARGET: begin
        load_target = 1'b1;
        state_d = S_IDLE;
      end
      S_LMSG: begin
        load_msg = 1'b1;
        cnt_d = '0;
        found_d = '0;
        wrapped_d = 1'b0;
        clr = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        // a new command outranks any result arriving in the same cycle
        if (new_target || new_msg) begin
          core_flush = 1'b1;
          clr = 1'b1;
          state_d = new_target ? S_LTARGET : S_LMSG;
        end else if (hit) begin
          core_flush = 1'b1;
          clr = 1'b1;
          found_d = hit_nonce;
          state_d = S_FOUND;
        end
`ifdef MINER_WDOG_EN
        else if (wd_fire) begin
          core_flush = 1'b1;
          clr = 1'b1;
          state_d = S_WDOG;
        end
`endif
        else if (state_q == S_RUN) begin
          if (any_idle && !wrapped_q) begin
            start = 1'b1;
            cnt_d = cnt_q + NONCE_W'(1);
            wrapped_d = &cnt_q;
            state_d = &cnt_q ? S_DRAIN : S_RUN;
          end
        end else if (busy == '0) state_d = S_EXHAUST;
      end
      default: state_d = new_target ? S_LTARGET : new_msg ? S_LMSG : state_q;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      found_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      found_q <= found_d;
      wrapped_q <= wrapped_d;
    end
  assign core_start = start ? pick : '0;
  assign core_nonce = start ? cnt_q : '0;
  assign btc_found = state_q == S_FOUND;
  assign found_nonce = found_q;
`ifdef MINER_WDOG_EN
  assign error = state_q == S_EXHAUST || state_q == S_WDOG;
`else
  assign error = state_q == S_EXHAUST;
`endif
endmodule

// File: tb/tb_mining_scheduler.sv
// tb_mining_scheduler: scoreboard bench, 4 cores with 4-bit nonces; watchdog checks follow MINER_WDOG_EN
module tb_mining_scheduler;
  localparam int NC = 4;
  localparam int NW = 4;
  localparam int LAT = 2;
`ifdef MINER_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic new_target = 1'b0;
  logic new_msg = 1'b0;
  logic [NC-1:0] core_done, core_valid, core_start;
  logic [NW-1:0] core_nonce, found_nonce;
  logic load_target, load_msg, core_flush, btc_found, error;
  logic manual;
  logic [NC-1:0] man_done, man_valid;
  logic [16:0] outs;
  logic [NC+NW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  mining_scheduler #(.NUM_CORES(NC), .NONCE_W(NW), .WDOG_CYCLES(8)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .new_target(new_target),
    .new_msg(new_msg),
    .core_done(core_done),
    .core_valid(core_valid),
    .load_target(load_target),
    .load_msg(load_msg),
    .core_start(core_start),
    .core_nonce(core_nonce),
    .core_flush(core_flush),
    .btc_found(btc_found),
    .found_nonce(found_nonce),
    .error(error)
  );
  assign outs = {load_target, load_msg, core_start, core_nonce, core_flush, btc_found, found_nonce, error};
  initial forever #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_run(input int a, input int b);
    for (int n = a; n <= b; n++) exp_q.push_back({NC'(1 << (n % NC)), NW'(n)});
  endtask
  task automatic go(input logic t, input logic m);
    #2 new_target = t;
    new_msg = m;
    @(negedge clk);
    #2 new_target = 1'b0;
    new_msg = 1'b0;
  endtask
  // core model: fixed-latency invalid replies in auto mode, scripted replies in manual mode
  initial begin
    logic [NC-1:0] st, dn;
    logic kill;
    logic [NC+NW-1:0] e;
    int cd [NC];
    core_done = '0;
    core_valid = '0;
    for (int i = 0; i < NC; i++) cd[i] = 0;
    forever begin
      @(negedge clk);
      #3;
      st = core_start;
      kill = core_flush | load_msg | !n_rst;
      if (st != '0) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("dispatch", 32'({st, core_nonce}), 32'(e));
      end
      @(posedge clk);
      #1;
      dn = '0;
      for (int i = 0; i < NC; i++) begin
        if (kill) cd[i] = 0;
        else if (cd[i] != 0) begin
          cd[i]--;
          dn[i] = (cd[i] == 0);
        end
        if (st[i] && !kill) cd[i] = LAT;
      end
      core_done = manual ? man_done : dn;
      core_valid = manual ? man_valid : '0;
    end
  end
  initial begin
    int n;
    manual = 1'b0;
    man_done = '0;
    man_valid = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs), 0);
    #2 n_rst = 1'b1;
    @(negedge clk);
    go(1'b1, 1'b0);
    chk("ltarget", 32'({load_target, load_msg}), 2);
    @(negedge clk);
    chk("ltarget_one", 32'({load_target, load_msg}), 0);
    go(1'b1, 1'b1);
    chk("prio_idle", 32'({load_target, load_msg}), 2);
    @(negedge clk);
    push_run(0, 15);
    go(1'b0, 1'b1);
    chk("lmsg", 32'({load_msg, btc_found, error}), 4);
    n = 0;
    while (!error && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("exhaust_cycles", 32'(n), 21);
    chk("exhaust_err", 32'({error, btc_found}), 2);
    chk("exhaust_q", 32'(exp_q.size()), 0);
    push_run(0, 2);
    go(1'b0, 1'b1);
    chk("restart", 32'({load_msg, error}), 2);
    repeat (4) @(negedge clk);
    #2 new_target = 1'b1;
    new_msg = 1'b1;
    #1 chk("abort_flush", 32'({core_flush, core_start}), 32'h10);
    @(negedge clk);
    chk("abort_ltarget", 32'({load_target, load_msg, core_flush}), 4);
    #2 new_target = 1'b0;
    new_msg = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({load_target, load_msg, core_flush}), 0);
    chk("abort_q", 32'(exp_q.size()), 0);
    manual = 1'b1;
    push_run(0, 7);
    go(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      #2 man_done = NC'(1 << i);
      @(negedge clk);
    end
    #2 man_done = '0;
    @(negedge clk);
    #2 man_done = 4'b1010;
    man_valid = 4'b1010;
    @(negedge clk);
    chk("found_flush", 32'({core_flush, core_start}), 32'h10);
    #2 man_done = '0;
    man_valid = '0;
    @(negedge clk);
    chk("found_state", 32'({btc_found, error, core_flush}), 4);
    chk("found_nonce", 32'(found_nonce), 5);
    chk("found_q", 32'(exp_q.size()), 0);
    push_run(0, 0);
    go(1'b0, 1'b1);
    chk("found_hold", 32'(found_nonce), 5);
    @(negedge clk);
    chk("found_clr", 32'({btc_found, found_nonce}), 0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chk("rst_run_outs", 32'(outs), 0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'(outs), 0);
    chk("rst_q", 32'(exp_q.size()), 0);
    push_run(0, 3);
    go(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 6) chk("wdog_flush", 32'(core_flush), 32'(WD && i == 7));
    end
    @(negedge clk);
    chk("wdog_err", 32'(error), 32'(WD));
    chk("wdog_q", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
